alg_unit: RTL and testbench
===========================

ALG_UNIT -- requirements
Module: alg_unit

Interface
REQ-001 The clock SHALL be clk  input  1  rising-edge clock for all state.
REQ-002 The reset SHALL be rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  EXE-stage load_alg_reg; request to begin an operation.
REQ-004 op  input  3  EXE-stage op_x_bits; op_mul selects multiply, op_div selects divide, any other code is ignored.
REQ-005 a  input  16  operand A (lc3b_word): multiplicand or dividend.
REQ-006 b  input  16  operand B (lc3b_word): multiplier or divisor.
REQ-007 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-008 busy  output  1  combinational pipeline stall request.
REQ-009 done  output  1  registered, one-cycle pulse marking valid results.
REQ-010 lo  output  16  registered result read via alu_res_sel 4'b1001: product[15:0] or quotient.
REQ-011 hi  output  16  registered result read via alu_res_sel 4'b1010: product[31:16] or remainder.

Function
REQ-012 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-013 In IDLE or DONE, start=1 with a valid op SHALL latch a and b and enter the matching state at the edge E0; operands are unsigned.
REQ-014 MUL SHALL run shift-add: 16 iterations at edges E1..E16 into a 32-bit accumulator, with no truncation before completion.
REQ-015 DIV SHALL run restoring division: 16 iterations at edges E1..E16, producing a 16-bit quotient and a 16-bit remainder.
REQ-016 At E16 the FSM SHALL enter DONE, write lo/hi and assert done for exactly one cycle; DONE returns to IDLE unless a new start is accepted.
REQ-017 lo/hi SHALL hold their values until the next completion, and SHALL be unaffected by flush or by ignored starts.
REQ-018 Division by zero SHALL bypass DIV: at E0 enter DONE with lo=16'hFFFF and hi=a, giving done one cycle after start.
REQ-019 busy SHALL be 1 whenever the state is MUL or DIV.
REQ-020 busy SHALL be 1 in IDLE/DONE when start=1 with a valid op, except the divide-by-zero case; otherwise busy SHALL be 0.
REQ-021 A start asserted while in MUL or DIV SHALL be ignored.
REQ-022 A start with an invalid op SHALL be ignored, leave the state unchanged and keep busy=0.
REQ-023 flush=1 SHALL force IDLE at the next edge with done=0 and SHALL take priority over start in the same cycle.
REQ-024 The iteration counter SHALL be 5 bits and SHALL never wrap; completion is decoded at count 16.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, done=0, lo=0, hi=0, counter=0 and accumulators=0, including mid-operation.
REQ-026 After rst_n deasserts, the first start SHALL be accepted in the same cycle.

Configuration
REQ-027 Macro ALG_EARLY_OUT_EN, when defined, SHALL end MUL once the remaining multiplier bits are zero, which is the shift-right form of b.
REQ-028 With ALG_EARLY_OUT_EN defined, b=0 SHALL go directly to DONE at E0 with lo=hi=0, and latency SHALL be bit-position(msb of b)+1 cycles.
REQ-029 Without ALG_EARLY_OUT_EN, MUL SHALL always take 16 iterations.
REQ-030 DIV latency SHALL be independent of ALG_EARLY_OUT_EN.

Structure
REQ-031 The shared package lc3b_types SHALL hold the alg_state_t enum and the ALG_ITER=16 constant.
REQ-032 alg_unit SHALL reuse the existing op_mul and op_div codes from lc3b_types.
REQ-033 FSM and counter SHALL live in one sub-module, alg_ctrl; the mul/div datapath SHALL remain in alg_unit.

Verification
REQ-034 MUL 3*5, macro off -> busy high for 16 cycles, done in cycle 16 after start, lo=16'h000F, hi=16'h0000.
REQ-035 MUL FFFF*FFFF -> lo=16'h0001, hi=16'hFFFE.
REQ-036 DIV 100/7 -> lo=16'h000E, hi=16'h0002 after 16 cycles.
REQ-037 DIV 1234/0 -> done after 1 cycle, lo=16'hFFFF, hi=16'h04D2, busy never asserted.
REQ-038 MUL 3*5 with flush at cycle 5 then rst_n pulse at cycle 8 -> no done, prior lo/hi kept after the flush, all outputs zero after reset.
REQ-039 ALG_EARLY_OUT_EN defined, MUL 3*5 -> done after 3 cycles; MUL 7*0 -> done after 1 cycle with lo=hi=0.

Source files
------------

// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types -- shared LC-3b type and constant definitions.
//
// Holds the EXE-stage op codes that select the multi-cycle arithmetic unit,
// the alg_unit FSM state enum, the result-write selector and the iteration
// constants shared by alg_ctrl and alg_unit.
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // EXE-stage op_x_bits codes that start the multi-cycle arithmetic unit.
  localparam logic [2:0] op_mul = 3'b101;
  localparam logic [2:0] op_div = 3'b110;

  // Iterations per multiply/divide and the width of the iteration counter.
  // The counter is one bit wider than needed for 0..15 so that the final
  // count of 16 is representable without wrapping.
  localparam int ALG_ITER  = 16;
  localparam int ALG_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alg_state_t;

  // Which value lands in lo/hi on a completion edge.
  typedef enum logic [2:0] {
    WR_NONE = 3'd0,
    WR_MUL  = 3'd1,  // full 32-bit product
    WR_DIV  = 3'd2,  // quotient / remainder
    WR_DIV0 = 3'd3,  // divide by zero: all-ones quotient, dividend remainder
    WR_ZERO = 3'd4   // multiply by zero short-cut
  } alg_wr_t;

  function automatic logic is_alg_op(input logic [2:0] op);
    return (op == op_mul) || (op == op_div);
  endfunction

endpackage

// File: rtl/alg_ctrl.sv
// ---------------------------------------------------------------------------
// alg_ctrl -- sequencing FSM and iteration counter for alg_unit.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    EXE-stage request and op code
//   b_zero       operand B is zero (divide-by-zero / multiply-by-zero bypass)
//   mul_early    remaining multiplier bits are zero after this iteration
//   flush        pipeline flush, aborts any operation in flight
//   busy         combinational stall request
//   done         registered one-cycle completion pulse
//   load         latch operands into the datapath this cycle
//   mul_step     datapath performs one shift-add iteration
//   div_step     datapath performs one restoring-division iteration
//   wr_sel       alg_wr_t code: what to write into lo/hi at this edge
//
// Configuration: ALG_EARLY_OUT_EN enables the multiply-by-zero bypass here;
// the datapath supplies mul_early only in that build (tied low otherwise).
// ---------------------------------------------------------------------------
module alg_ctrl
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       b_zero,
  input  logic       mul_early,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       load,
  output logic       mul_step,
  output logic       div_step,
  output logic [2:0] wr_sel
);

  alg_state_t             state_q, state_d;
  logic [ALG_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   done_d;
  alg_wr_t                wr_d;

  logic idle_like;
  logic req;
  logic div0;
  logic mul0;
  logic last_iter;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign req       = idle_like && start && is_alg_op(op);
  assign div0      = (op == op_div) && b_zero;
`ifdef ALG_EARLY_OUT_EN
  assign mul0      = (op == op_mul) && b_zero;
`else
  assign mul0      = 1'b0;
`endif
  // Completion is decoded when the count is about to reach ALG_ITER.
  assign last_iter = (cnt_q == ALG_CNT_W'(ALG_ITER - 1));

  // A divide by zero completes at the very next edge, so it never stalls.
  assign busy     = (state_q == MUL) || (state_q == DIV) || (req && !div0);
  assign load     = req && !flush;
  assign mul_step = (state_q == MUL);
  assign div_step = (state_q == DIV);
  assign wr_sel   = wr_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_d    = WR_NONE;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          cnt_d   = '0;
          state_d = IDLE;
          if (req) begin
            if (div0) begin
              state_d = DONE;
              done_d  = 1'b1;
              wr_d    = WR_DIV0;
            end else if (mul0) begin
              state_d = DONE;
              done_d  = 1'b1;
              wr_d    = WR_ZERO;
            end else begin
              state_d = (op == op_mul) ? MUL : DIV;
            end
          end
        end
        MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (last_iter || mul_early) begin
            state_d = DONE;
            done_d  = 1'b1;
            wr_d    = WR_MUL;
          end
        end
        DIV: begin
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d = DONE;
            done_d  = 1'b1;
            wr_d    = WR_DIV;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
    end
  end

endmodule

// File: rtl/alg_unit.sv
// ---------------------------------------------------------------------------
// alg_unit -- multi-cycle unsigned 16x16 multiply / 16/16 divide unit.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        EXE-stage load_alg_reg
//   op           EXE-stage op_x_bits (op_mul / op_div, others ignored)
//   a, b         operands: multiplicand/dividend, multiplier/divisor
//   flush        pipeline flush, aborts an operation in flight
//   busy         combinational pipeline stall request
//   done         registered one-cycle pulse when lo/hi are freshly written
//   lo           product[15:0] or quotient
//   hi           product[31:16] or remainder
//
// Sequencing lives in alg_ctrl; this module holds the shift-add multiplier,
// the restoring divider and the lo/hi result registers.
//
// Configuration: define ALG_EARLY_OUT_EN to end a multiply as soon as the
// remaining multiplier bits are zero (and short-cut b == 0).
// ---------------------------------------------------------------------------
module alg_unit
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [15:0] lo,
  output logic [15:0] hi
);

  logic       load, mul_step, div_step, mul_early;
  logic [2:0] wr_sel;
  alg_wr_t    wr;

  // Multiplier: product accumulates in acc while the multiplicand shifts
  // left and the multiplier shifts right, one bit per iteration.
  logic [31:0] acc, mcand, acc_nx;
  lc3b_word    mplier;

  // Restoring divider: quot starts as the dividend and shifts its bits into
  // rem from the top while quotient bits enter from the bottom.
  lc3b_word    rem, quot, divisor, rem_nx, quot_nx, diff;
  logic [16:0] shifted;
  logic        fits;

  assign wr = alg_wr_t'(wr_sel);

  assign acc_nx  = mplier[0] ? (acc + mcand) : acc;

  assign shifted = {rem, quot[15]};
  assign fits    = (shifted >= {1'b0, divisor});
  // When the trial subtraction fits, the true difference is below divisor,
  // so the low 16 bits are exact.
  assign diff    = shifted[15:0] - divisor;
  assign rem_nx  = fits ? diff : shifted[15:0];
  assign quot_nx = {quot[14:0], fits};

`ifdef ALG_EARLY_OUT_EN
  assign mul_early = ~|mplier[15:1];
`else
  assign mul_early = 1'b0;
`endif

  alg_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .b_zero    (~|b),
    .mul_early (mul_early),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .load      (load),
    .mul_step  (mul_step),
    .div_step  (div_step),
    .wr_sel    (wr_sel)
  );

  // NOTE: the working registers are reset too, so a reset mid-operation
  // leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= {16'h0000, a};
      mplier  <= b;
      rem     <= '0;
      quot    <= a;
      divisor <= b;
    end else begin
      if (mul_step) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (div_step) begin
        rem  <= rem_nx;
        quot <= quot_nx;
      end
    end
  end

  // Results change only on a completion edge; flushes and ignored starts
  // leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else begin
      unique case (wr)
        WR_MUL: begin
          lo <= acc_nx[15:0];
          hi <= acc_nx[31:16];
        end
        WR_DIV: begin
          lo <= quot_nx;
          hi <= rem_nx;
        end
        WR_DIV0: begin
          lo <= 16'hFFFF;
          hi <= a;
        end
        WR_ZERO: begin
          lo <= '0;
          hi <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alg_unit.sv
// ---------------------------------------------------------------------------
// tb_alg_unit -- self-checking bench for alg_unit.
// Expected results come from plain arithmetic (*, /, %) and a latency rule;
// the bench tracks the last completed result to check that lo/hi hold.
// ---------------------------------------------------------------------------
module tb_alg_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] lo, hi;

  int checks = 0;
  int errors = 0;

  // Last result the unit should be holding.
  logic [15:0] mlo = 16'h0000;
  logic [15:0] mhi = 16'h0000;

  alg_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .lo    (lo),
    .hi    (hi)
  );

  always #5 clk = ~clk;

  // Edges after the latching edge until done is visible.
  function automatic int mul_latency(input logic [15:0] y);
`ifdef ALG_EARLY_OUT_EN
    int n = 0;
    for (int i = 0; i < 16; i++) if (y[i]) n = i + 1;
    return n;
`else
    return (y == 16'h0000) ? 16 : 16;
`endif
  endfunction

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles: no done, no stall, results held.
  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || lo !== mlo || hi !== mhi) begin
        errors++;
        $display("FAIL %s idle%0d: done=%b busy=%b lo=%h hi=%h, want done=0 busy=0 lo=%h hi=%h",
                 name, i, done, busy, lo, hi, mlo, mhi);
      end
    end
  endtask

  // Issue one valid operation and follow it to completion.  Optionally pokes
  // a second start while the first is in flight, which must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, y,
                        input string name, input bit poke);
    logic [31:0] prod;
    logic [15:0] elo, ehi;
    int          lat;
    logic        ebusy;
    if (o == op_mul) begin
      prod = {16'h0000, x} * {16'h0000, y};
      elo  = prod[15:0];
      ehi  = prod[31:16];
      lat  = mul_latency(y);
    end else if (y == 16'h0000) begin
      elo = 16'hFFFF;
      ehi = x;
      lat = 0;
    end else begin
      elo = x / y;
      ehi = x % y;
      lat = 16;
    end
    ebusy = !(o == op_div && y == 16'h0000);

    start = 1'b1; op = o; a = x; b = y;
    #1;
    checks++;
    if (busy !== ebusy) begin
      errors++;
      $display("FAIL %s busy_at_start: got %b want %b", name, busy, ebusy);
    end
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    for (int j = 0; j <= lat; j++) begin
      if (j == lat) begin
        checks++;
        if (done !== 1'b1 || lo !== elo || hi !== ehi) begin
          errors++;
          $display("FAIL %s result: done=%b lo=%h hi=%h, want done=1 lo=%h hi=%h",
                   name, done, lo, hi, elo, ehi);
        end
        mlo = elo;
        mhi = ehi;
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || lo !== mlo || hi !== mhi) begin
          errors++;
          $display("FAIL %s iter%0d: done=%b busy=%b lo=%h hi=%h, want done=0 busy=1 lo=%h hi=%h",
                   name, j, done, busy, lo, hi, mlo, mhi);
        end
        if (poke && j == 4) begin
          start = 1'b1; op = (o == op_mul) ? op_div : op_mul; b = 16'h0000;
        end
        tick();
        start = 1'b0;
      end
    end
  endtask

  // Start with an unrecognised op code: nothing may happen.
  task automatic invalid_op(input logic [2:0] o, input string name);
    start = 1'b1; op = o; a = 16'($urandom); b = 16'($urandom_range(0, 3));
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b want 0", name, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    idle(2, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 16'h0000 || hi !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: done=%b busy=%b lo=%h hi=%h, want all zero", done, busy, lo, hi);
    end
    // The first start is offered in the very cycle reset is released.
    rst_n = 1'b1;
    run_op(op_mul, 16'd3, 16'd5, "mul_3x5_after_reset", 1'b0);
  endtask

  task automatic test_mul();
    idle(2, "mul_gap");
    run_op(op_mul, 16'd3, 16'd5, "mul_3x5", 1'b0);
    checks++;
    if (lo !== 16'h000F || hi !== 16'h0000) begin
      errors++;
      $display("FAIL mul_3x5_const: lo=%h hi=%h want 000f 0000", lo, hi);
    end
    idle(1, "mul_gap2");
    run_op(op_mul, 16'hFFFF, 16'hFFFF, "mul_ffff", 1'b0);
    checks++;
    if (lo !== 16'h0001 || hi !== 16'hFFFE) begin
      errors++;
      $display("FAIL mul_ffff_const: lo=%h hi=%h want 0001 fffe", lo, hi);
    end
    idle(1, "mul_gap3");
    run_op(op_mul, 16'h1234, 16'h8001, "mul_poke", 1'b1);
  endtask

  task automatic test_div();
    idle(1, "div_gap");
    run_op(op_div, 16'd100, 16'd7, "div_100_7", 1'b0);
    checks++;
    if (lo !== 16'h000E || hi !== 16'h0002) begin
      errors++;
      $display("FAIL div_100_7_const: lo=%h hi=%h want 000e 0002", lo, hi);
    end
    idle(1, "div_gap2");
    run_op(op_div, 16'd1234, 16'd0, "div_by_zero", 1'b0);
    checks++;
    if (lo !== 16'hFFFF || hi !== 16'h04D2) begin
      errors++;
      $display("FAIL div0_const: lo=%h hi=%h want ffff 04d2", lo, hi);
    end
    idle(1, "div_gap3");
    run_op(op_div, 16'hFFFF, 16'd1, "div_by_one", 1'b1);
    run_op(op_div, 16'd5, 16'hFFFF, "div_small", 1'b0);
  endtask

  task automatic test_invalid();
    idle(1, "inv_gap");
    for (int i = 0; i < 8; i++) begin
      if (3'(i) != op_mul && 3'(i) != op_div) invalid_op(3'(i), "invalid_op");
    end
  endtask

  task automatic test_back_to_back();
    run_op(op_mul, 16'd300, 16'd211, "b2b_mul", 1'b0);
    run_op(op_div, 16'd5000, 16'd0, "b2b_div0", 1'b0);
    run_op(op_div, 16'd5000, 16'd0, "b2b_div0_again", 1'b0);
    run_op(op_div, 16'd65000, 16'd99, "b2b_div", 1'b0);
    run_op(op_mul, 16'd0, 16'd77, "b2b_mul_zero_a", 1'b0);
    idle(2, "b2b_tail");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int          r;
      logic [15:0] x, y;
      r = int'($urandom_range(0, 9));
      x = 16'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if (r < 4)      run_op(op_mul, x, y, "rand_mul", 1'($urandom));
      else if (r < 8) run_op(op_div, x, y, "rand_div", 1'($urandom));
      else            invalid_op((r == 8) ? 3'b000 : 3'b111, "rand_invalid");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)), "rand_gap");
    end
    idle(1, "rand_end");
  endtask

  task automatic test_flush_reset();
    // A prior result is held; flush mid-multiply must not disturb it.
    run_op(op_div, 16'd1000, 16'd3, "pre_flush", 1'b0);
    start = 1'b1; op = op_mul; a = 16'd3; b = 16'd5;
    tick();                                     // E0
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      flush = (c == 5);
      tick();
      flush = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== (c < 5) || lo !== mlo || hi !== mhi) begin
        errors++;
        $display("FAIL flush_c%0d: done=%b busy=%b lo=%h hi=%h, want done=0 busy=%b lo=%h hi=%h",
                 c, done, busy, lo, hi, (c < 5), mlo, mhi);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 16'h0000 || hi !== 16'h0000) begin
      errors++;
      $display("FAIL flush_then_reset: done=%b busy=%b lo=%h hi=%h, want all zero", done, busy, lo, hi);
    end
    mlo = 16'h0000; mhi = 16'h0000;
    tick();
    rst_n = 1'b1;
    idle(20, "after_reset");

    // Reset in the middle of a divide.
    run_op(op_mul, 16'hFFFF, 16'hFFFF, "pre_reset_mid", 1'b0);
    start = 1'b1; op = op_div; a = 16'd50000; b = 16'd3;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 16'h0000 || hi !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_div: done=%b busy=%b lo=%h hi=%h, want all zero", done, busy, lo, hi);
    end
    mlo = 16'h0000; mhi = 16'h0000;
    tick();
    rst_n = 1'b1;
    idle(20, "after_mid_reset");
  endtask

  task automatic test_flush_priority();
    run_op(op_mul, 16'd12, 16'd11, "pre_prio", 1'b0);
    // Flush in the DONE cycle: done must not repeat, result stays.
    flush = 1'b1;
    idle(1, "flush_in_done");
    flush = 1'b0;
    // Flush beats a divide-by-zero start that would complete next edge.
    start = 1'b1; op = op_div; a = 16'hABCD; b = 16'h0000; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (done !== 1'b0 || lo !== mlo || hi !== mhi) begin
      errors++;
      $display("FAIL flush_prio_div0: done=%b lo=%h hi=%h, want done=0 lo=%h hi=%h",
               done, lo, hi, mlo, mhi);
    end
    // Flush beats a multiply start: nothing may ever complete.
    start = 1'b1; op = op_mul; a = 16'd9; b = 16'd9; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    idle(20, "flush_prio_mul");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_invalid();
    test_back_to_back();
    test_random();
    test_flush_priority();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
